// File: rtl/wt_cache_pkg.sv
// Shared types and helpers for the write-through cache invalidation path.
// Line addresses and the line-alignment function live here.
package wt_cache_pkg;

    typedef logic [63:0] inval_line_t;

    typedef struct packed {
        int unsigned XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32'd64};

    function automatic inval_line_t inval_line_align(
        input inval_line_t addr,
        input int unsigned off_w
    );
        inval_line_t mask;
        mask = '1;
        mask = mask << off_w;
        return addr & mask;
    endfunction

endpackage

// File: rtl/wt_inval_queue.sv
// Snoop invalidation FIFO: line-aligns interconnect snoops and feeds the D$.
// Optional duplicate-line merging is enabled with `define WT_INVAL_DEDUP_EN.
module wt_inval_queue
    import wt_cache_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg     = cva6_cfg_empty,
    parameter int unsigned Depth       = 8,
    parameter int unsigned LineOffsetW = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [63:0]              snoop_addr_i,
    input  logic                     snoop_valid_i,
    output logic                     snoop_ready_o,
    output logic [63:0]              inval_addr_o,
    output logic                     inval_valid_o,
    input  logic                     inval_ready_i,
    output logic [$clog2(Depth):0]   occupancy_o,
    output logic                     empty_o,
    output logic                     dedup_hit_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(Depth);

    if (Depth < 2 || (Depth & (Depth - 1)) != 0 || CVA6Cfg.XLEN == 0) begin : g_bad_param
        $error("wt_inval_queue: Depth must be a power of two >= 2");
    end

    inval_line_t     mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic            push;
    logic            pop;
    logic            hit;
    logic            write;
    inval_line_t     line;

    assign snoop_ready_o = (count_q != Full);
    assign inval_valid_o = (count_q != '0);
    assign inval_addr_o  = mem_q[rd_ptr_q];
    assign occupancy_o   = count_q;
    assign empty_o       = (count_q == '0);

    assign push  = snoop_valid_i & snoop_ready_o;
    assign pop   = inval_valid_o & inval_ready_i;
    assign line  = inval_line_align(snoop_addr_i, LineOffsetW);
    assign write = push & ~hit;

`ifdef WT_INVAL_DEDUP_EN
    logic            dedup_q;
    logic [PtrW-1:0] idx;

    // Match the incoming line against live entries; a head leaving this cycle does not count.
    always_comb begin
        hit = 1'b0;
        idx = rd_ptr_q;
        for (int unsigned i = 0; i < Depth; i++) begin
            idx = rd_ptr_q + PtrW'(i);
            if ((CntW'(i) < count_q) && !(i == 0 && pop) && (mem_q[idx] == line)) begin
                hit = 1'b1;
            end
        end
        hit = hit & push;
    end

    // One-cycle pulse marking a merged snoop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dedup_q <= 1'b0;
        end else begin
            dedup_q <= hit;
        end
    end

    assign dedup_hit_o = dedup_q;
`else
    assign hit         = 1'b0;
    assign dedup_hit_o = 1'b0;
`endif

    // Storage, pointers and occupancy; reset drops every queued entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (write) begin
                mem_q[wr_ptr_q] <= line;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CntW'(write) - CntW'(pop);
        end
    end

endmodule

// File: tb/tb_wt_inval_queue.sv
// Directed bench for wt_inval_queue: vector table plus reset/dedup sequences.
// Expectations track the WT_INVAL_DEDUP_EN setting of the build.
module tb_wt_inval_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] snoop_addr;
    logic        snoop_valid;
    logic        snoop_ready;
    logic [63:0] inval_addr;
    logic        inval_valid;
    logic        inval_ready;
    logic [3:0]  occ;
    logic        empty;
    logic        dedup;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic        v;
        logic [63:0] a;
        logic        r;
        logic        e_rdy;
        logic        e_val;
        logic [63:0] e_addr;
        logic [3:0]  e_occ;
    } vec_t;

    vec_t tbl[$];

    wt_inval_queue #(
        .Depth(8),
        .LineOffsetW(4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .snoop_addr_i  (snoop_addr),
        .snoop_valid_i (snoop_valid),
        .snoop_ready_o (snoop_ready),
        .inval_addr_o  (inval_addr),
        .inval_valid_o (inval_valid),
        .inval_ready_i (inval_ready),
        .occupancy_o   (occ),
        .empty_o       (empty),
        .dedup_hit_o   (dedup)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [63:0] a, input logic r);
        snoop_valid = v;
        snoop_addr  = a;
        inval_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        snoop_valid = 1'b0;
        snoop_addr  = '0;
        inval_ready = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, snoop_ready, 1'b1);
        chk({tag, "_valid"}, inval_valid, 1'b0);
        chk({tag, "_occ"}, occ, 4'd0);
        chk({tag, "_empty"}, empty, 1'b1);
        chk({tag, "_dedup"}, dedup, 1'b0);
    endtask

    initial begin
        // align, fill to full, stall, drain, concurrent wrap, drain to empty
        tbl.push_back('{1, 64'h8000_1237, 1, 1, 1, 64'h8000_1230, 1});
        tbl.push_back('{1, 64'h1_001f, 0, 1, 1, 64'h8000_1230, 2});
        tbl.push_back('{1, 64'h1_0020, 0, 1, 1, 64'h8000_1230, 3});
        tbl.push_back('{1, 64'h1_0031, 0, 1, 1, 64'h8000_1230, 4});
        tbl.push_back('{1, 64'h1_0042, 0, 1, 1, 64'h8000_1230, 5});
        tbl.push_back('{1, 64'h1_0053, 0, 1, 1, 64'h8000_1230, 6});
        tbl.push_back('{1, 64'h1_0064, 0, 1, 1, 64'h8000_1230, 7});
        tbl.push_back('{1, 64'h1_0075, 0, 0, 1, 64'h8000_1230, 8});
        tbl.push_back('{1, 64'h1_0080, 0, 0, 1, 64'h8000_1230, 8});
        tbl.push_back('{0, 64'h0,      1, 1, 1, 64'h1_0010,    7});
        tbl.push_back('{0, 64'h0,      1, 1, 1, 64'h1_0020,    6});
        tbl.push_back('{0, 64'h0,      1, 1, 1, 64'h1_0030,    5});
        tbl.push_back('{0, 64'h0,      1, 1, 1, 64'h1_0040,    4});
        tbl.push_back('{0, 64'h0,      1, 1, 1, 64'h1_0050,    3});
        tbl.push_back('{1, 64'h1_0088, 1, 1, 1, 64'h1_0060,    3});
        tbl.push_back('{1, 64'h1_0099, 1, 1, 1, 64'h1_0070,    3});
        tbl.push_back('{1, 64'h1_00aa, 1, 1, 1, 64'h1_0080,    3});
        tbl.push_back('{0, 64'h0,      1, 1, 1, 64'h1_0090,    2});
        tbl.push_back('{0, 64'h0,      1, 1, 1, 64'h1_00a0,    1});
        tbl.push_back('{0, 64'h0,      1, 1, 0, 64'h0,         0});

        do_reset();
        chk_idle("reset");
        chk("reset_addr", inval_addr, 64'h0);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].a, tbl[i].r);
            chk($sformatf("v%0d_ready", i), snoop_ready, tbl[i].e_rdy);
            chk($sformatf("v%0d_valid", i), inval_valid, tbl[i].e_val);
            chk($sformatf("v%0d_occ", i), occ, tbl[i].e_occ);
            chk($sformatf("v%0d_empty", i), empty, tbl[i].e_occ == 0);
            chk($sformatf("v%0d_dedup", i), dedup, 1'b0);
            if (tbl[i].e_val) begin
                chk($sformatf("v%0d_addr", i), inval_addr, tbl[i].e_addr);
            end
        end

        // asynchronous reset in the middle of traffic
        step(1, 64'h5000, 0);
        step(1, 64'h6000, 0);
        step(1, 64'h7000, 0);
        chk("pre_rst_occ", occ, 4'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        chk("async_rst_addr", inval_addr, 64'h0);
        snoop_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("post_rst");

        // duplicate line against a queued entry
        step(1, 64'h1000, 0);
        step(1, 64'h2000, 0);
        step(1, 64'h1008, 0);
`ifdef WT_INVAL_DEDUP_EN
        chk("dedup_occ", occ, 4'd2);
        chk("dedup_pulse", dedup, 1'b1);
`else
        chk("dedup_occ", occ, 4'd3);
        chk("dedup_pulse", dedup, 1'b0);
`endif
        step(0, 64'h0, 0);
        chk("dedup_pulse_end", dedup, 1'b0);
        chk("dedup_head", inval_addr, 64'h1000);

        // head leaving in the same cycle must not absorb the push
        do_reset();
        step(1, 64'h1000, 0);
        step(1, 64'h2000, 0);
        step(1, 64'h1004, 1);
        chk("pop_dup_occ", occ, 4'd2);
        chk("pop_dup_pulse", dedup, 1'b0);
        chk("pop_dup_head", inval_addr, 64'h2000);
        step(0, 64'h0, 1);
        chk("pop_dup_next", inval_addr, 64'h1000);
        chk("pop_dup_occ2", occ, 4'd1);
        step(0, 64'h0, 1);
        chk("pop_dup_empty", empty, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
